// File: rtl/fb_scanout.sv
// Frame-buffer read side: raster-order reads locked to DrawX/DrawY, sync/blank realignment
// with the returned pixel data, and the vsync-committed double-buffer page flip.
module fb_scanout #(
  parameter int            FB_W     = 640,
  parameter int            FB_H     = 480,
  parameter int            DW       = 8,
  parameter int            AW       = 19,
  parameter int            SCALE_SH = 0,
  parameter int            DBL_BUF  = 0,
  parameter logic [DW-1:0] BG_COLOR = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          pix_en,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          blank_in,
  input  logic          swap_req,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] rgb_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          blank_out,
  output logic          buffer_using,
  output logic          swap_ack,
  output logic          frame_start
);

  localparam int            LW        = FB_W >> SCALE_SH;
  localparam int            LH        = FB_H >> SCALE_SH;
  localparam int            PAGE      = LW * LH;
  localparam logic [AW-1:0] LINE_STEP = AW'(LW);
  localparam logic [AW-1:0] PAGE_BASE = AW'(PAGE);
  localparam logic [AW-1:0] LB_LIMIT  = AW'(PAGE - 2 * LW);
  localparam logic [9:0]    X_LIM     = 10'(FB_W);
  localparam logic [9:0]    Y_LIM     = 10'(FB_H);
  localparam logic [9:0]    Y_MASK    = 10'((1 << SCALE_SH) - 1);

  typedef enum logic {IDLE, PENDING} flip_state_t;

  logic [1:0]    rst_q;
  logic          rst_int_n;
  logic          sync_ok;
  logic [AW-1:0] line_base;
  logic [9:0]    last_y;
  logic          bg_s0, hs_s0, vs_s0, blank_s0;
  logic [DW-1:0] data_s1;
  logic          hs_s1, vs_s1, blank_s1;
  flip_state_t   flip_state;
  logic          vs_prev;

  logic          start, ok_now, in_frame, y_step, vs_fall, flip_now;
  logic [9:0]    xs_c;
  logic [AW-1:0] lb_next, lb_cur, page_off, addr_next;

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_int_n = rst_q[1];

  assign start    = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign ok_now   = sync_ok | start;
  assign in_frame = (DrawX < X_LIM) && (DrawY < Y_LIM);
  assign xs_c     = (DrawX < X_LIM) ? (DrawX >> SCALE_SH) : 10'd0;
  // Line base advances by one stored line per new source line; clamped at the last line.
  assign y_step   = (DrawY != last_y) && ((DrawY & Y_MASK) == 10'd0) && (line_base <= LB_LIMIT);
  assign lb_next  = (DrawY == 10'd0) ? '0 : (y_step ? line_base + LINE_STEP : line_base);
  assign lb_cur   = (DrawX == 10'd0) ? lb_next : line_base;
  assign page_off = buffer_using ? PAGE_BASE : '0;
  assign addr_next = page_off + lb_cur + AW'(xs_c);

  assign vs_fall  = vs_prev & ~vs_in;
  assign flip_now = vs_fall && ((flip_state == PENDING) || swap_req);

  always_ff @(posedge Clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync_ok     <= 1'b0;
      line_base   <= '0;
      last_y      <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      bg_s0       <= 1'b0;
      hs_s0       <= 1'b1;
      vs_s0       <= 1'b1;
      blank_s0    <= 1'b0;
      data_s1     <= '0;
      hs_s1       <= 1'b1;
      vs_s1       <= 1'b1;
      blank_s1    <= 1'b0;
      rgb_out     <= '0;
      hs_out      <= 1'b1;
      vs_out      <= 1'b1;
      blank_out   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && start;
      if (pix_en) begin
        sync_ok <= ok_now;
        if (DrawX == 10'd0) begin
          line_base <= lb_next;
          last_y    <= DrawY;
        end
        rd_addr   <= addr_next;
        rd_en     <= ok_now && blank_in && in_frame;
        bg_s0     <= ok_now && blank_in;
        hs_s0     <= hs_in;
        vs_s0     <= vs_in;
        blank_s0  <= blank_in;
        // rd_en here still belongs to the previous pixel, whose data has now landed.
        data_s1   <= rd_en ? rd_data : (bg_s0 ? BG_COLOR : '0);
        hs_s1     <= hs_s0;
        vs_s1     <= vs_s0;
        blank_s1  <= blank_s0;
        rgb_out   <= data_s1;
        hs_out    <= hs_s1;
        vs_out    <= vs_s1;
        blank_out <= blank_s1;
      end
    end
  end

  // A flip request waits for the next falling vsync; a request arriving on that very edge counts.
  always_ff @(posedge Clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      flip_state   <= IDLE;
      buffer_using <= 1'b0;
      swap_ack     <= 1'b0;
      vs_prev      <= 1'b1;
    end else begin
      swap_ack <= 1'b0;
      if (pix_en) begin
        vs_prev <= vs_in;
        if (flip_now) begin
          swap_ack   <= 1'b1;
          flip_state <= IDLE;
          if (DBL_BUF != 0) buffer_using <= ~buffer_using;
        end else if (swap_req) begin
          flip_state <= PENDING;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: three configurations share one coordinate stream; a scoreboard
// checks the delayed pixel/sync outputs and a vector table checks read addresses.
module tb_fb_scanout;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        blank_in = 1'b0;
  logic        swap_req = 1'b0;

  logic        rd_en_a, rd_en_b, rd_en_c;
  logic [18:0] rd_addr_a, rd_addr_b, rd_addr_c;
  logic [7:0]  rd_data_a, rd_data_b, rd_data_c;
  logic [7:0]  rgb_a, rgb_b, rgb_c;
  logic        hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, blank_a, blank_b, blank_c;
  logic        buf_a, buf_b, buf_c, ack_a, ack_b, ack_c, fs_a, fs_b, fs_c;

  always #5 Clk = ~Clk;

  fb_scanout u_a (
    .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in), .swap_req(swap_req),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rgb_out(rgb_a),
    .hs_out(hs_a), .vs_out(vs_a), .blank_out(blank_a), .buffer_using(buf_a),
    .swap_ack(ack_a), .frame_start(fs_a));

  fb_scanout #(.SCALE_SH(1), .DBL_BUF(1)) u_b (
    .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in), .swap_req(swap_req),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rgb_out(rgb_b),
    .hs_out(hs_b), .vs_out(vs_b), .blank_out(blank_b), .buffer_using(buf_b),
    .swap_ack(ack_b), .frame_start(fs_b));

  fb_scanout #(.FB_W(320), .FB_H(240), .BG_COLOR(8'h2A)) u_c (
    .Clk(Clk), .Reset(Reset), .pix_en(pix_en), .DrawX(DrawX), .DrawY(DrawY),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in), .swap_req(swap_req),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rgb_out(rgb_c),
    .hs_out(hs_c), .vs_out(vs_c), .blank_out(blank_c), .buffer_using(buf_c),
    .swap_ack(ack_c), .frame_start(fs_c));

  // Frame-buffer contents are mem[i] = i[7:0], read one clock after rd_en.
  always @(posedge Clk) begin
    if (rd_en_a) rd_data_a <= rd_addr_a[7:0];
    if (rd_en_b) rd_data_b <= rd_addr_b[7:0];
    if (rd_en_c) rd_data_c <= rd_addr_c[7:0];
  end

  typedef struct {
    logic [7:0] rgb_a;
    logic [7:0] rgb_b;
    logic [7:0] rgb_c;
    logic       hs;
    logic       vs;
    logic       blank;
  } exp_t;

  typedef struct {
    int   x;
    int   y;
    logic blank;
    logic hs;
    int   addr_a;
    int   addr_b;
    int   addr_c;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_pass = 0;
  logic tb_ok = 1'b0;
  int   exp_page_b = 0;
  logic fs_at, fs_next, ack_at_a, ack_at_b, ack_next_b;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void model(input int x, input int y, input logic blk, input int w,
                                input int h, input int sh, input int page, input logic [7:0] bg,
                                output logic en, output logic [7:0] rgb);
    int addr;
    en   = tb_ok && blk && (x < w) && (y < h);
    addr = page + (y >> sh) * (w >> sh) + (x >> sh);
    rgb  = en ? 8'(addr) : ((tb_ok && blk) ? bg : 8'h00);
  endfunction

  task automatic pushResetRecords();
    exp_t r;
    r.rgb_a = 8'h00; r.rgb_b = 8'h00; r.rgb_c = 8'h00;
    r.hs = 1'b1; r.vs = 1'b1; r.blank = 1'b0;
    sb.delete();
    sb.push_back(r);
    sb.push_back(r);
  endtask

  task automatic applyStimulus(input int x, input int y, input logic blk, input logic hsv,
                               input logic vsv);
    exp_t e, got;
    logic en_a, en_b, en_c;
    if (x == 0 && y == 0) tb_ok = 1'b1;
    model(x, y, blk, 640, 480, 0, 0, 8'h00, en_a, e.rgb_a);
    model(x, y, blk, 640, 480, 1, exp_page_b, 8'h00, en_b, e.rgb_b);
    model(x, y, blk, 320, 240, 0, 0, 8'h2A, en_c, e.rgb_c);
    e.hs = hsv; e.vs = vsv; e.blank = blk;
    sb.push_back(e);
    DrawX = 10'(x); DrawY = 10'(y);
    hs_in = hsv; vs_in = vsv; blank_in = blk;
    pix_en = 1'b1;
    @(posedge Clk); #1;
    pix_en = 1'b0;
    fs_at = fs_a; ack_at_a = ack_a; ack_at_b = ack_b;
    checkOutput("rd_en_a", 32'(rd_en_a), 32'(en_a));
    checkOutput("rd_en_b", 32'(rd_en_b), 32'(en_b));
    checkOutput("rd_en_c", 32'(rd_en_c), 32'(en_c));
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
    end else begin
      got = sb.pop_front();
      checkOutput("rgb_a", 32'(rgb_a), 32'(got.rgb_a));
      checkOutput("rgb_b", 32'(rgb_b), 32'(got.rgb_b));
      checkOutput("rgb_c", 32'(rgb_c), 32'(got.rgb_c));
      checkOutput("hs_out", 32'(hs_a), 32'(got.hs));
      checkOutput("vs_out", 32'(vs_b), 32'(got.vs));
      checkOutput("blank_out", 32'(blank_c), 32'(got.blank));
    end
    @(posedge Clk); #1;
    ack_next_b = ack_b; fs_next = fs_a;
  endtask

  initial begin
    vecs[0]  = '{0,   0, 1'b1, 1'b1, 0,    0,   0};
    vecs[1]  = '{1,   0, 1'b1, 1'b1, 1,    0,   1};
    vecs[2]  = '{0,   1, 1'b1, 1'b1, 640,  0,   320};
    vecs[3]  = '{0,   2, 1'b1, 1'b1, 1280, 320, 640};
    vecs[4]  = '{0,   3, 1'b1, 1'b1, 1920, 320, 960};
    vecs[5]  = '{5,   3, 1'b1, 1'b1, 1925, 322, 965};
    vecs[6]  = '{0,   4, 1'b1, 1'b1, 2560, 640, 1280};
    vecs[7]  = '{6,   4, 1'b1, 1'b1, 2566, 643, 1286};
    vecs[8]  = '{400, 4, 1'b1, 1'b1, 2960, 840, 1280};
    vecs[9]  = '{700, 4, 1'b0, 1'b0, 2560, 640, 1280};
    vecs[10] = '{0,   5, 1'b1, 1'b1, 3200, 640, 1600};
    vecs[11] = '{7,   5, 1'b1, 1'b1, 3207, 643, 1607};

    // Power-on reset.
    repeat (5) @(posedge Clk);
    #1;
    checkOutput("reset_rgb", 32'(rgb_a), 0);
    checkOutput("reset_rd_en", 32'(rd_en_a), 0);
    checkOutput("reset_rd_addr", 32'(rd_addr_a), 0);
    checkOutput("reset_hs", 32'(hs_a), 1);
    checkOutput("reset_vs", 32'(vs_a), 1);
    checkOutput("reset_blank", 32'(blank_a), 0);
    checkOutput("reset_buf_b", 32'(buf_b), 0);
    checkOutput("reset_ack", 32'(ack_b), 0);
    checkOutput("reset_fs", 32'(fs_a), 0);
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    pushResetRecords();

    // Pixels before the first frame start must not read.
    applyStimulus(10, 2, 1'b1, 1'b1, 1'b1);
    applyStimulus(11, 2, 1'b1, 1'b1, 1'b1);

    // Raster walk from the frame origin.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].blank, vecs[i].hs, 1'b1);
      checkOutput($sformatf("rd_addr_a[%0d]", i), 32'(rd_addr_a), vecs[i].addr_a);
      checkOutput($sformatf("rd_addr_b[%0d]", i), 32'(rd_addr_b), vecs[i].addr_b);
      checkOutput($sformatf("rd_addr_c[%0d]", i), 32'(rd_addr_c), vecs[i].addr_c);
      checkOutput($sformatf("frame_start[%0d]", i), 32'(fs_at), 32'(i == 0));
      checkOutput($sformatf("frame_start_next[%0d]", i), 32'(fs_next), 0);
    end

    // Mid-line reset: outputs drop at once, reads stay off until the next frame start.
    #2 Reset = 1'b0;
    #1;
    checkOutput("midreset_rgb", 32'(rgb_a), 0);
    checkOutput("midreset_rd_en", 32'(rd_en_a), 0);
    checkOutput("midreset_rd_addr", 32'(rd_addr_a), 0);
    checkOutput("midreset_hs", 32'(hs_a), 1);
    checkOutput("midreset_blank", 32'(blank_a), 0);
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    tb_ok = 1'b0;
    pushResetRecords();
    applyStimulus(8, 5, 1'b1, 1'b1, 1'b1);
    applyStimulus(9, 5, 1'b1, 1'b1, 1'b1);

    // Page flip requested mid-frame, committed only at the falling vsync.
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b1);
    swap_req = 1'b1;
    applyStimulus(0, 100, 1'b0, 1'b1, 1'b1);
    checkOutput("flip_wait_buf", 32'(buf_b), 0);
    checkOutput("flip_wait_ack", 32'(ack_at_b), 0);
    applyStimulus(0, 480, 1'b0, 1'b1, 1'b1);
    checkOutput("flip_wait2_buf", 32'(buf_b), 0);
    applyStimulus(0, 490, 1'b0, 1'b1, 1'b0);
    checkOutput("flip_buf_b", 32'(buf_b), 1);
    checkOutput("flip_ack_b", 32'(ack_at_b), 1);
    checkOutput("flip_ack_b_width", 32'(ack_next_b), 0);
    checkOutput("single_ack_a", 32'(ack_at_a), 1);
    checkOutput("single_buf_a", 32'(buf_a), 0);
    exp_page_b = 76800;
    applyStimulus(0, 491, 1'b0, 1'b1, 1'b0);
    checkOutput("no_second_ack", 32'(ack_at_b), 0);
    checkOutput("flip_hold_buf", 32'(buf_b), 1);
    applyStimulus(0, 492, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b1);
    checkOutput("page1_origin_addr", 32'(rd_addr_b), 76800);
    applyStimulus(1, 0, 1'b1, 1'b1, 1'b1);
    applyStimulus(0, 1, 1'b0, 1'b1, 1'b1);

    // Request still held: flips back at the following vsync.
    applyStimulus(0, 490, 1'b0, 1'b1, 1'b0);
    checkOutput("reflip_ack_b", 32'(ack_at_b), 1);
    checkOutput("reflip_buf_b", 32'(buf_b), 0);
    checkOutput("reflip_ack_a", 32'(ack_at_a), 1);
    exp_page_b = 0;
    swap_req = 1'b0;
    applyStimulus(0, 491, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, 492, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_ack_b", 32'(ack_at_b), 0);
    checkOutput("idle_ack_a", 32'(ack_at_a), 0);
    checkOutput("idle_buf_b", 32'(buf_b), 0);
    applyStimulus(0, 493, 1'b0, 1'b1, 1'b0);
    applyStimulus(0, 494, 1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
